// File: rtl/usb_serial_fifo_ep.sv
`default_nettype none
// ============================================================================
// usb_serial_fifo_ep : buffered CDC-style serial endpoint pair with RX/TX
// FIFOs, max-packet packetising, idle-timeout flush and ZLP termination.
// Revision: 1.0
// ============================================================================
module usb_serial_fifo_ep #(
  parameter int RX_DEPTH     = 64,
  parameter int TX_DEPTH     = 64,
  parameter int MAX_PKT      = 64,
  parameter int FLUSH_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        out_ep_req,
  input  logic                        out_ep_grant,
  input  logic                        out_ep_data_avail,
  input  logic                        out_ep_setup,
  output logic                        out_ep_data_get,
  input  logic [7:0]                  out_ep_data,
  output logic                        out_ep_stall,
  input  logic                        out_ep_acked,
  output logic                        in_ep_req,
  input  logic                        in_ep_grant,
  input  logic                        in_ep_data_free,
  output logic                        in_ep_data_put,
  output logic [7:0]                  in_ep_data,
  output logic                        in_ep_data_done,
  output logic                        in_ep_stall,
  input  logic                        in_ep_acked,
  input  logic [7:0]                  uart_tx_data,
  input  logic                        uart_tx_strobe,
  output logic                        uart_tx_ready,
  output logic [7:0]                  uart_rx_data,
  output logic                        uart_rx_valid,
  input  logic                        uart_rx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int PC_W  = $clog2(MAX_PKT) + 1;
  localparam int TM_W  = $clog2(FLUSH_CYCLES + 1);

  localparam logic [RX_AW-1:0] RX_PTR_ONE = RX_AW'(1);
  localparam logic [RX_AW:0]   RX_CNT_ONE = (RX_AW + 1)'(1);
  localparam logic [RX_AW:0]   RX_FULL_C  = (RX_AW + 1)'(RX_DEPTH);
  localparam logic [TX_AW-1:0] TX_PTR_ONE = TX_AW'(1);
  localparam logic [TX_AW:0]   TX_CNT_ONE = (TX_AW + 1)'(1);
  localparam logic [TX_AW:0]   TX_FULL_C  = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [TX_AW:0]   TX_PKT_C   = (TX_AW + 1)'(MAX_PKT);
  localparam logic [PC_W-1:0]  PKT_MAX_C  = PC_W'(MAX_PKT);
  localparam logic [PC_W-1:0]  PKT_ONE    = PC_W'(1);
  localparam logic [TM_W-1:0]  FLUSH_C    = TM_W'(FLUSH_CYCLES);
  localparam logic [TM_W-1:0]  TM_ONE     = TM_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_FILL     = 3'd2,
    S_DONE     = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_e;

  wire unused_out_acked = out_ep_acked;

  // RX FIFO (host -> user), first-word-fall-through
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
  logic             rx_full, rx_wr, rx_rd;

  assign rx_full         = (rx_cnt_q == RX_FULL_C);
  assign out_ep_req      = reset_n && out_ep_data_avail && !rx_full;
  assign out_ep_data_get = reset_n && out_ep_grant && out_ep_data_avail &&
                           (!rx_full || out_ep_setup);
  assign rx_wr           = out_ep_data_get && !out_ep_setup;
  assign uart_rx_valid   = (rx_cnt_q != '0);
  assign uart_rx_data    = rx_mem_q[rx_rptr_q];
  assign rx_rd           = uart_rx_valid && uart_rx_ready;
  assign rx_level        = rx_cnt_q;
  assign out_ep_stall    = 1'b0;
  assign in_ep_stall     = 1'b0;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_wr && !rx_rd)      rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
    else if (!rx_wr && rx_rd) rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
    end else begin
      if (rx_wr) rx_wptr_q <= rx_wptr_q + RX_PTR_ONE;
      if (rx_rd) rx_rptr_q <= rx_rptr_q + RX_PTR_ONE;
      rx_cnt_q <= rx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem_q[rx_wptr_q] <= out_ep_data;
  end

  // TX FIFO (user -> host)
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;
  logic             tx_ready_q, tx_wr, tx_rd, tx_nonempty;

  assign tx_wr         = uart_tx_strobe && tx_ready_q;
  assign tx_nonempty   = (tx_cnt_q != '0);
  assign uart_tx_ready = tx_ready_q;
  assign tx_level      = tx_cnt_q;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_wr && !tx_rd)      tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
    else if (!tx_wr && tx_rd) tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_ready_q <= 1'b0;
    end else begin
      if (tx_wr) tx_wptr_q <= tx_wptr_q + TX_PTR_ONE;
      if (tx_rd) tx_rptr_q <= tx_rptr_q + TX_PTR_ONE;
      tx_cnt_q   <= tx_cnt_d;
      tx_ready_q <= (tx_cnt_d != TX_FULL_C);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_wr) tx_mem_q[tx_wptr_q] <= uart_tx_data;
  end

  // IN packetiser
  state_e          state_q, state_d;
  logic [PC_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [TM_W-1:0] timer_q, timer_d;
  logic            zlp_q, zlp_d, put_q, put_d;
  logic [7:0]      in_data_q, in_data_d;

  assign tx_rd = (state_q == S_FILL) && in_ep_grant && in_ep_data_free &&
                 tx_nonempty && (pkt_cnt_q < PKT_MAX_C);

  always_comb begin
    state_d   = state_q;
    pkt_cnt_d = pkt_cnt_q;
    zlp_d     = zlp_q;
    put_d     = 1'b0;
    in_data_d = in_data_q;
    case (state_q)
      S_IDLE: begin
        if ((tx_cnt_q >= TX_PKT_C) ||
            ((timer_q == FLUSH_C) && (tx_nonempty || zlp_q))) begin
          state_d   = S_REQ;
          pkt_cnt_d = '0;
        end
      end
      S_REQ: if (in_ep_grant) state_d = S_FILL;
      S_FILL: begin
        if (tx_rd) begin
          in_data_d = tx_mem_q[tx_rptr_q];
          put_d     = 1'b1;
          pkt_cnt_d = pkt_cnt_q + PKT_ONE;
        end
        // A take and the exit condition are mutually exclusive by construction
        if ((pkt_cnt_q == PKT_MAX_C) || !tx_nonempty) state_d = S_DONE;
      end
      S_DONE: begin
        zlp_d   = (pkt_cnt_q == PKT_MAX_C);
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: if (in_ep_acked) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    timer_d = timer_q;
    if (tx_wr)
      timer_d = '0;
    else if ((state_q == S_IDLE) && (tx_nonempty || zlp_q) && (timer_q != FLUSH_C))
      timer_d = timer_q + TM_ONE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pkt_cnt_q <= '0;
      timer_q   <= '0;
      zlp_q     <= 1'b0;
      put_q     <= 1'b0;
      in_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pkt_cnt_q <= pkt_cnt_d;
      timer_q   <= timer_d;
      zlp_q     <= zlp_d;
      put_q     <= put_d;
      in_data_q <= in_data_d;
    end
  end

  assign in_ep_req       = (state_q == S_REQ) || (state_q == S_FILL) || (state_q == S_DONE);
  assign in_ep_data_done = (state_q == S_DONE);
  assign in_ep_data_put  = put_q;
  assign in_ep_data      = in_data_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_serial_fifo_ep.sv
`default_nettype none
// ============================================================================
// tb_usb_serial_fifo_ep : scoreboard bench for usb_serial_fifo_ep.
// Revision: 1.0
// ============================================================================
module tb_usb_serial_fifo_ep;

  localparam int RXD = 16;
  localparam int TXD = 64;
  localparam int MP  = 64;
  localparam int FC  = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       out_ep_req, out_ep_grant, out_ep_data_avail, out_ep_setup;
  logic       out_ep_data_get, out_ep_stall, out_ep_acked;
  logic [7:0] out_ep_data;
  logic       in_ep_req, in_ep_grant, in_ep_data_free, in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done, in_ep_stall, in_ep_acked;
  logic [7:0] uart_tx_data, uart_rx_data;
  logic       uart_tx_strobe, uart_tx_ready, uart_rx_valid, uart_rx_ready;
  logic [$clog2(TXD):0] tx_level;
  logic [$clog2(RXD):0] rx_level;

  assign in_ep_grant = in_ep_req;

  usb_serial_fifo_ep #(
    .RX_DEPTH(RXD), .TX_DEPTH(TXD), .MAX_PKT(MP), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .out_ep_req(out_ep_req), .out_ep_grant(out_ep_grant),
    .out_ep_data_avail(out_ep_data_avail), .out_ep_setup(out_ep_setup),
    .out_ep_data_get(out_ep_data_get), .out_ep_data(out_ep_data),
    .out_ep_stall(out_ep_stall), .out_ep_acked(out_ep_acked),
    .in_ep_req(in_ep_req), .in_ep_grant(in_ep_grant),
    .in_ep_data_free(in_ep_data_free), .in_ep_data_put(in_ep_data_put),
    .in_ep_data(in_ep_data), .in_ep_data_done(in_ep_data_done),
    .in_ep_stall(in_ep_stall), .in_ep_acked(in_ep_acked),
    .uart_tx_data(uart_tx_data), .uart_tx_strobe(uart_tx_strobe),
    .uart_tx_ready(uart_tx_ready), .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .tx_level(tx_level), .rx_level(rx_level)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  tx_exp[$];
  logic [7:0]  rx_exp[$];
  int          exp_len[$];
  int          cur_len = 0;
  int          pkts = 0;
  int          ack_cd = 0;
  int          rx_recv = 0;
  bit          rx_hold = 1'b0;
  bit          done_prev = 1'b0;
  logic [31:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Host IN side, RX consumer and scoreboard pops, all sampled mid-cycle
  always @(negedge clk) begin
    in_ep_acked = 1'b0;
    if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) in_ep_acked = 1'b1;
    end
    if (in_ep_data_put) begin
      mon_e = (tx_exp.size() != 0) ? 32'(tx_exp.pop_front()) : 32'h1FF;
      chk("in_byte", 32'(in_ep_data), mon_e);
      cur_len++;
    end
    if (in_ep_data_done) begin
      chk("done_single_cycle", 32'(done_prev), 32'd0);
      mon_e = (exp_len.size() != 0) ? 32'(exp_len.pop_front()) : 32'hDEAD;
      chk("pkt_len", 32'(cur_len), mon_e);
      cur_len = 0;
      pkts++;
      ack_cd = 3;
    end
    done_prev = in_ep_data_done;
    uart_rx_ready = !rx_hold;
    if (uart_rx_valid && uart_rx_ready) begin
      mon_e = (rx_exp.size() != 0) ? 32'(rx_exp.pop_front()) : 32'h1FF;
      chk("rx_byte", 32'(uart_rx_data), mon_e);
      rx_recv++;
    end
  end

  task automatic rx_offer(input logic [7:0] b, input bit setup, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 5 && !ok; t++) begin
      out_ep_data_avail = 1'b1;
      out_ep_data       = b;
      out_ep_setup      = setup;
      #1;
      if (out_ep_data_get) begin
        ok = 1'b1;
        if (!setup) rx_exp.push_back(b);
      end
      @(negedge clk);
    end
    out_ep_data_avail = 1'b0;
    out_ep_setup      = 1'b0;
  endtask

  task automatic tx_push(input logic [7:0] b);
    int t = 0;
    while (!uart_tx_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!uart_tx_ready) chk("tx_ready_timeout", 32'(uart_tx_ready), 32'd1);
    else tx_exp.push_back(b);
    uart_tx_data   = b;
    uart_tx_strobe = 1'b1;
    @(negedge clk);
    uart_tx_strobe = 1'b0;
  endtask

  task automatic count_to_req(output int n);
    n = 0;
    while (!in_ep_req && n < FC + 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_drain(input int target);
    int t = 0;
    while (rx_recv < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("rx_recv", 32'(rx_recv), 32'(target));
    chk("rx_level_empty", 32'(rx_level), 32'd0);
  endtask

  task automatic wait_pkts(input int target);
    int t = 0;
    while (pkts < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("pkt_count", 32'(pkts), 32'(target));
  endtask

  initial begin
    int n, acc, base, lvl;
    bit ok;
    reset_n = 1'b0;
    out_ep_grant = 1'b1;
    out_ep_data_avail = 1'b1;
    out_ep_setup = 1'b0;
    out_ep_data = 8'h00;
    out_ep_acked = 1'b0;
    in_ep_data_free = 1'b1;
    uart_tx_data = 8'h00;
    uart_tx_strobe = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_in_req", 32'(in_ep_req), 0);
    chk("rst_put", 32'(in_ep_data_put), 0);
    chk("rst_done", 32'(in_ep_data_done), 0);
    chk("rst_in_data", 32'(in_ep_data), 0);
    chk("rst_rx_valid", 32'(uart_rx_valid), 0);
    chk("rst_tx_ready", 32'(uart_tx_ready), 0);
    chk("rst_out_req", 32'(out_ep_req), 0);
    chk("rst_levels", 32'({tx_level, rx_level}), 0);
    out_ep_data_avail = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_tx_ready", 32'(uart_tx_ready), 1);
    chk("post_rst_tx_level", 32'(tx_level), 0);
    chk("post_rst_rx_level", 32'(rx_level), 0);

    // OUT bytes delivered in order
    for (int i = 0; i < 5; i++) begin
      rx_offer(8'h41 + 8'(i), 1'b0, ok);
      chk("rx_get", 32'(ok), 1);
    end
    wait_drain(5);

    rx_offer(8'hAA, 1'b1, ok);
    chk("setup_get", 32'(ok), 1);
    chk("setup_dropped", 32'(rx_level), 0);

    // RX backpressure to full, then drain
    rx_hold = 1'b1;
    @(negedge clk);
    acc = 0;
    for (int i = 0; i < RXD + 3; i++) begin
      rx_offer(8'h60 + 8'(i), 1'b0, ok);
      if (!ok) break;
      acc++;
    end
    chk("rx_accepted", 32'(acc), 32'(RXD));
    chk("rx_full_level", 32'(rx_level), 32'(RXD));
    out_ep_data_avail = 1'b1;
    #1;
    chk("rx_full_out_req", 32'(out_ep_req), 0);
    out_ep_data_avail = 1'b0;
    rx_hold = 1'b0;
    for (int i = acc; i < RXD + 3; i++) begin
      rx_offer(8'h60 + 8'(i), 1'b0, ok);
      chk("rx_get_after_release", 32'(ok), 1);
    end
    wait_drain(5 + RXD + 3);

    // Partial packet flushed after idle timeout, no ZLP
    base = pkts;
    exp_len.push_back(3);
    tx_push(8'h10);
    tx_push(8'h11);
    tx_push(8'h12);
    count_to_req(n);
    chk("flush_latency", 32'(n), 32'(FC + 1));
    wait_pkts(base + 1);
    repeat (FC + 10) @(negedge clk);
    chk("no_zlp_after_partial", 32'(pkts), 32'(base + 1));

    // Exactly MAX_PKT bytes: full packet then ZLP
    base = pkts;
    exp_len.push_back(MP);
    exp_len.push_back(0);
    for (int i = 0; i < MP; i++) tx_push(8'h80 + 8'(i));
    count_to_req(n);
    chk("full_pkt_latency", 32'(n), 1);
    wait_pkts(base + 2);
    repeat (2 * FC) @(negedge clk);
    chk("single_zlp", 32'(pkts), 32'(base + 2));

    // 70 bytes with full-FIFO rejects and a mid-packet data_free stall
    base = pkts;
    exp_len.push_back(MP);
    exp_len.push_back(6);
    in_ep_data_free = 1'b0;
    for (int i = 0; i < TXD; i++) tx_push(8'(i * 3));
    chk("tx_full_ready", 32'(uart_tx_ready), 0);
    chk("tx_full_level", 32'(tx_level), 32'(TXD));
    uart_tx_data = 8'hEE;
    uart_tx_strobe = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reject_level", 32'(tx_level), 32'(TXD));
    end
    uart_tx_strobe = 1'b0;
    in_ep_data_free = 1'b1;
    repeat (20) @(negedge clk);
    in_ep_data_free = 1'b0;
    @(negedge clk);
    lvl = int'(tx_level);
    repeat (10) @(negedge clk);
    chk("stall_level", 32'(tx_level), 32'(lvl));
    chk("stall_req_held", 32'(in_ep_req), 1);
    in_ep_data_free = 1'b1;
    for (int i = TXD; i < TXD + 6; i++) tx_push(8'(i * 3));
    wait_pkts(base + 2);
    repeat (FC + 10) @(negedge clk);
    chk("no_zlp_after_6", 32'(pkts), 32'(base + 2));
    chk("tx_level_final", 32'(tx_level), 0);
    chk("tx_sb_empty", 32'(tx_exp.size()), 0);
    chk("len_sb_empty", 32'(exp_len.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/usb_serial_fifo_ep.md
Name: usb_serial_fifo_ep

Overview:
- Buffered, packetising USB CDC-style serial endpoint pair.
- Sits between the USB core's OUT/IN endpoint interfaces and a byte-stream user port in the same clock domain.
- Adds parametrised RX/TX FIFOs, valid/ready backpressure, max-packet packetisation, idle-timeout flush and zero-length-packet (ZLP) termination.

Parameters:
- RX_DEPTH, 64, RX FIFO depth in bytes; power of two, at least 2.
- TX_DEPTH, 64, TX FIFO depth in bytes; power of two, at least MAX_PKT.
- MAX_PKT, 64, max IN packet payload in bytes; 8, 16, 32 or 64.
- FLUSH_CYCLES, 4096, idle cycles before a partial TX packet is sent; at least 1.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- out_ep_req  out  1  request OUT buffer access.
- out_ep_grant  in  1  OUT access granted.
- out_ep_data_avail  in  1  OUT byte available.
- out_ep_setup  in  1  current OUT data is a SETUP packet.
- out_ep_data_get  out  1  consume current OUT byte.
- out_ep_data  in  8  current OUT byte.
- out_ep_stall  out  1  tied 0.
- out_ep_acked  in  1  unused.
- in_ep_req  out  1  request IN buffer access.
- in_ep_grant  in  1  IN access granted.
- in_ep_data_free  in  1  IN buffer has space for one byte.
- in_ep_data_put  out  1  write in_ep_data this cycle.
- in_ep_data  out  8  IN byte.
- in_ep_data_done  out  1  packet complete, one-cycle pulse.
- in_ep_stall  out  1  tied 0.
- in_ep_acked  in  1  host ACKed the last IN packet.
- uart_tx_data  in  8  user byte to host.
- uart_tx_strobe  in  1  write uart_tx_data; honoured only when uart_tx_ready.
- uart_tx_ready  out  1  TX FIFO not full.
- uart_rx_data  out  8  byte from host; valid while uart_rx_valid.
- uart_rx_valid  out  1  RX FIFO non-empty.
- uart_rx_ready  in  1  user accepts uart_rx_data.
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy.
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.

Behaviour:
Reset:
- While reset_n is low at a clk edge, both FIFOs are emptied, the FSM goes to IDLE, the flush timer clears and zlp_pending clears.
- All registered outputs go to 0: in_ep_req, in_ep_data_put, in_ep_data_done, in_ep_data, uart_rx_valid, levels.
- uart_tx_ready=0 and out_ep_req=0 while reset_n is low.
- Reset mid-packet drops in_ep_req the next cycle without a done pulse; buffered data is discarded.

OUT path (combinational on the endpoint side):
- out_ep_req = out_ep_data_avail && !rx_full.
- out_ep_data_get = out_ep_grant && out_ep_data_avail && (!rx_full || out_ep_setup).
- A got byte is written to the RX FIFO at that edge, except when out_ep_setup=1: SETUP bytes are consumed and dropped.
- RX FIFO is first-word-fall-through: uart_rx_data shows the head byte; the pop happens when uart_rx_valid && uart_rx_ready.
- A full FIFO that is popped and written in the same cycle is not possible, because get is gated on the registered full flag; pop and write on a non-full FIFO in the same cycle leaves the level unchanged.

TX FIFO:
- uart_tx_ready = !tx_full, registered.
- A strobe while not ready is ignored, and no byte is lost from the FIFO.
- Write and pop in the same cycle are allowed.

Flush timer:
- Clears on any accepted TX write.
- Otherwise increments while in IDLE and (tx non-empty or zlp_pending), saturating at FLUSH_CYCLES.

IN packetiser FSM:
- IDLE
  - Go to REQ when tx_level >= MAX_PKT, or when timer == FLUSH_CYCLES and (tx non-empty or zlp_pending).
  - Clear pkt_cnt on exit.
- REQ
  - in_ep_req=1.
  - When in_ep_grant, go to FILL.
- FILL
  - in_ep_req=1.
  - Each cycle with in_ep_grant && in_ep_data_free && tx non-empty && pkt_cnt < MAX_PKT: register in_ep_data = head, pulse in_ep_data_put next cycle, pop, pkt_cnt += 1.
  - Losing the grant or data_free stalls the FSM in place.
  - When pkt_cnt == MAX_PKT or the TX FIFO is empty, go to DONE. A ZLP entry reaches DONE with pkt_cnt=0.
- DONE
  - in_ep_data_done=1 for exactly one cycle, in_ep_req held.
  - zlp_pending <= (pkt_cnt == MAX_PKT).
  - Go to WAIT_ACK.
- WAIT_ACK
  - in_ep_req=0.
  - On in_ep_acked, go to IDLE. The next packet is not started before the ACK.

Latency:
- A full packet is requested on the cycle after the MAX_PKT-th write.
- A partial packet is requested FLUSH_CYCLES+1 cycles after the last write.

Test Plan:
- Reset with reset_n=0 for 2 cycles, then release -> all outputs 0 during reset; uart_tx_ready=1 and tx_level=rx_level=0 one cycle after release.
- Host sends 5 OUT bytes 0x41..0x45 with uart_rx_ready=1 -> uart_rx_valid pulses deliver 0x41..0x45 in order; rx_level returns to 0.
- Hold uart_rx_ready=0 and offer RX_DEPTH+3 bytes -> get stops at rx_level=RX_DEPTH and out_ep_req=0; releasing ready drains all bytes in order with none lost.
- Write 3 TX bytes 0x10,0x11,0x12 then idle -> in_ep_req rises FLUSH_CYCLES+1 cycles later; 3 puts; done pulse; no ZLP after ACK.
- Write exactly MAX_PKT bytes then idle -> one 64-byte packet with done; after ACK and FLUSH_CYCLES, a ZLP follows (req, done, zero puts).
- Write 70 bytes, drop in_ep_data_free for 10 cycles mid-packet, and assert uart_tx_strobe while full -> packets of 64 then 6 bytes, byte order preserved, rejected writes leave tx_level unchanged.
